// File: rtl/eth_gen_pkg.sv
// Shared types and constants for the eth_traffic_gen GMII frame generator.
// Holds the FSM and pattern enums, the fixed line bytes and the CRC/LFSR constants.
package eth_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_SFD  = 3'd2,
    ST_PAY  = 3'd3,
    ST_FCS  = 3'd4,
    ST_IFG  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PAT_INC   = 2'd0,
    PAT_CONST = 2'd1,
    PAT_PRBS  = 2'd2,
    PAT_INDEX = 2'd3
  } pattern_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3).
  localparam logic [7:0]  LFSR_TAPS     = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    return {r[6:0], ^(r & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
// Bits are consumed LSB first, matching GMII byte order on the wire.
module eth_crc32_d8
  import eth_gen_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  dat,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ dat[b]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/eth_traffic_gen.sv
// GMII Ethernet frame/burst generator with payload patterns and txer injection.
// Define ETH_GEN_FCS_EN to append a CRC-32 FCS after each payload.
module eth_traffic_gen
  import eth_gen_pkg::*;
#(
  parameter int MAX_LEN      = 1514,
  parameter int MIN_IFG      = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] frame_len,
  input  logic [15:0] frame_cnt,
  input  logic [7:0]  ifg,
  input  logic [1:0]  pattern,
  input  logic [7:0]  seed,
  input  logic        err_en,
  input  logic [15:0] err_pos,
  output logic        busy,
  output logic        done,
  output logic [15:0] frames_sent,
  output logic [7:0]  tx_dat,
  output logic        tx_en,
  output logic        tx_er,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] MAX_LEN_W  = 16'(MAX_LEN);
  localparam logic [7:0]  MIN_IFG_W  = 8'(MIN_IFG);
  localparam logic [15:0] PRE_LAST   = 16'(PREAMBLE_LEN - 1);

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;

  // Burst configuration captured when a start is accepted.
  logic [15:0] len_l;
  logic [15:0] fcnt_l;
  logic [7:0]  gap_l;
  pattern_t    pat_l;
  logic [7:0]  seed_l;
  logic        err_en_l;
  logic [15:0] err_pos_l;
  logic        stop_seen;
  logic [7:0]  lfsr;

  logic [15:0] len_eff;
  logic [7:0]  gap_eff;
  logic        accept;
  logic        burst_end;
  logic [7:0]  pay_byte;
  logic [7:0]  dat_n;
  logic        en_n;
  logic        er_n;

  assign accept    = (state == ST_IDLE) && start;
  assign dbg_state = state;
  assign burst_end = stop_seen || stop ||
                     ((fcnt_l != 16'd0) && (frames_sent == fcnt_l));

  always_comb begin
    len_eff = frame_len;
    if (frame_len == 16'd0) begin
      len_eff = 16'd1;
    end else if (frame_len > MAX_LEN_W) begin
      len_eff = MAX_LEN_W;
    end
    gap_eff = (ifg < MIN_IFG_W) ? MIN_IFG_W : ifg;
  end

`ifdef ETH_GEN_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_nx;
  logic [31:0] fcs_word;
  logic [7:0]  fcs_byte;

  eth_crc32_d8 u_crc (
    .crc_in  (crc),
    .dat     (dat_n),
    .crc_out (crc_nx)
  );

  assign fcs_word = ~crc;

  always_comb begin
    case (cnt_n[1:0])
      2'd0:    fcs_byte = fcs_word[7:0];
      2'd1:    fcs_byte = fcs_word[15:8];
      2'd2:    fcs_byte = fcs_word[23:16];
      default: fcs_byte = fcs_word[31:24];
    endcase
  end
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    case (state)
      ST_IDLE: begin
        cnt_n = 16'd0;
        if (start) state_n = ST_PRE;
      end
      ST_PRE: begin
        if (cnt == PRE_LAST) begin
          state_n = ST_SFD;
          cnt_n   = 16'd0;
        end
      end
      ST_SFD: begin
        state_n = ST_PAY;
        cnt_n   = 16'd0;
      end
      ST_PAY: begin
        if (cnt == len_l - 16'd1) begin
          cnt_n = 16'd0;
`ifdef ETH_GEN_FCS_EN
          state_n = ST_FCS;
`else
          state_n = ST_IFG;
`endif
        end
      end
      ST_FCS: begin
        if (cnt == 16'd3) begin
          state_n = ST_IFG;
          cnt_n   = 16'd0;
        end
      end
      ST_IFG: begin
        if (cnt == {8'd0, gap_l} - 16'd1) begin
          cnt_n   = 16'd0;
          state_n = burst_end ? ST_IDLE : ST_PRE;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 16'd0;
      end
    endcase
  end

  always_comb begin
    case (pat_l)
      PAT_INC:   pay_byte = seed_l + cnt_n[7:0];
      PAT_CONST: pay_byte = seed_l;
      PAT_PRBS:  pay_byte = lfsr;
      default:   pay_byte = frames_sent[7:0];
    endcase
  end

  // Line outputs are decoded from the next state so they register in step with it.
  always_comb begin
    dat_n = 8'h00;
    en_n  = 1'b0;
    er_n  = 1'b0;
    case (state_n)
      ST_PRE: begin
        dat_n = PREAMBLE_BYTE;
        en_n  = 1'b1;
      end
      ST_SFD: begin
        dat_n = SFD_BYTE;
        en_n  = 1'b1;
      end
      ST_PAY: begin
        dat_n = pay_byte;
        en_n  = 1'b1;
        er_n  = err_en_l && (cnt_n == err_pos_l);
      end
`ifdef ETH_GEN_FCS_EN
      ST_FCS: begin
        dat_n = fcs_byte;
        en_n  = 1'b1;
      end
`endif
      default: begin
        dat_n = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= 16'd0;
      len_l       <= 16'd1;
      fcnt_l      <= 16'd0;
      gap_l       <= MIN_IFG_W;
      pat_l       <= PAT_INC;
      seed_l      <= 8'h00;
      err_en_l    <= 1'b0;
      err_pos_l   <= 16'd0;
      stop_seen   <= 1'b0;
      lfsr        <= 8'h01;
      frames_sent <= 16'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      tx_dat      <= 8'h00;
      tx_en       <= 1'b0;
      tx_er       <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy   <= (state_n != ST_IDLE);
      done   <= (state == ST_IFG) && (state_n == ST_IDLE);
      tx_dat <= dat_n;
      tx_en  <= en_n;
      tx_er  <= er_n;

      if (accept) begin
        len_l       <= len_eff;
        fcnt_l      <= frame_cnt;
        gap_l       <= gap_eff;
        pat_l       <= pattern_t'(pattern);
        seed_l      <= seed;
        err_en_l    <= err_en;
        err_pos_l   <= err_pos;
        stop_seen   <= 1'b0;
        frames_sent <= 16'd0;
      end else begin
        if ((state != ST_IDLE) && stop) stop_seen <= 1'b1;
        if ((state_n == ST_IFG) && (state != ST_IFG)) frames_sent <= frames_sent + 16'd1;
      end

      if (state_n == ST_SFD) begin
        lfsr <= (seed_l == 8'h00) ? 8'h01 : seed_l;
      end else if (state_n == ST_PAY) begin
        lfsr <= lfsr_next(lfsr);
      end
    end
  end

`ifdef ETH_GEN_FCS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      crc <= CRC_INIT;
    end else if (state_n == ST_SFD) begin
      crc <= CRC_INIT;
    end else if (state_n == ST_PAY) begin
      crc <= crc_nx;
    end
  end
`endif

endmodule

// File: doc/eth_traffic_gen.md
Name: eth_traffic_gen

Overview:
Synthesizable, parametrised GMII-style Ethernet frame generator.
- Drives the 8-bit txd/txen/txer side of rgmii_if, one byte per txclk at all speeds. At 10/100 the clock itself is slowed.
- Compared with the simulation-only packet task generator, it adds:
  - programmable multi-frame bursts and inter-frame gap;
  - selectable payload patterns;
  - positioned error injection;
  - optional CRC-32 FCS.
- Used for loopback bring-up and on-board link testing.

Parameters:
MAX_LEN, 1514, maximum payload bytes per frame; larger requests are clamped.
MIN_IFG, 12, minimum inter-frame gap in cycles; smaller requests are raised to this.
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD.

Ports:
clk  in  1  byte clock (txclk of rgmii_if)
reset  in  1  synchronous, active-high
start  in  1  pulse; begin a burst (ignored while busy)
stop  in  1  pulse; finish the current frame plus its IFG, then go idle
frame_len  in  16  payload bytes per frame
frame_cnt  in  16  frames per burst; 0 = continuous until stop
ifg  in  8  inter-frame gap in cycles
pattern  in  2  0 = increment, 1 = constant, 2 = PRBS8, 3 = frame index
seed  in  8  pattern seed
err_en  in  1  enable error injection
err_pos  in  16  payload byte index that carries txer
busy  out  1  burst in progress
done  out  1  one-cycle pulse at burst end
frames_sent  out  16  frames completed since the last start (wraps)
tx_dat  out  8  GMII data
tx_en  out  1  GMII enable
tx_er  out  1  GMII error

Behaviour:
Reset and configuration
- Reset values: tx_dat = 0, tx_en = 0, tx_er = 0, busy = 0, done = 0, frames_sent = 0. State goes to IDLE.
- Reset mid-frame: all outputs are 0 the following cycle. No partial-frame completion.
- All inputs are latched at start, when start is sampled in IDLE. Later input changes do not affect the running burst.
- Effective length L = clamp(frame_len, 1, MAX_LEN).
- Effective gap G = max(ifg, MIN_IFG).

Outputs are registered. start sampled at cycle T gives:
- busy = 1 from T+1;
- the first preamble byte at T+1.

State machine (IDLE -> PRE -> SFD -> PAY -> FCS -> IFG -> PRE | IDLE):
- PRE: PREAMBLE_LEN cycles, tx_dat = 0x55, tx_en = 1.
- SFD: 1 cycle, tx_dat = 0xD5.
- PAY: L cycles. Payload byte index i runs 0..L-1.
- FCS: 4 cycles. Absent when the FCS macro is off (PAY goes straight to IFG).
- IFG: G cycles, tx_en = 0, tx_dat = 0.

End of frame and end of burst
- frames_sent increments in the cycle after the last byte of a frame.
- After IFG, go to IDLE if either holds:
  - frames_sent has reached frame_cnt (frame_cnt ≠ 0);
  - a stop was seen during the frame.
  Otherwise go to PRE.
- Going to IDLE: done = 1 for one cycle and busy = 0 in that same cycle.
- stop in IDLE is ignored. start and stop in the same IDLE cycle: start wins.

Payload patterns
- 0: byte = seed + i, mod 256.
- 1: byte = seed.
- 2: 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1. Loaded with seed (0 replaced by 0x01) at each frame start. Output the register, then advance.
- 3: byte = frames_sent[7:0] of the current frame.

Error injection
- When err_en = 1 and i == err_pos: tx_er = 1 for that one payload cycle. tx_dat is unchanged.
- err_pos ≥ L: no error is injected.
- tx_er is 0 in all other cycles.

Optional Feature:
ETH_GEN_FCS_EN
- Defined:
  - FCS state present.
  - CRC-32 over the payload bytes only (reflected, poly 0xEDB88320, init 0xFFFFFFFF, final XOR 0xFFFFFFFF).
  - Transmitted least-significant byte first.
  - An injected error byte is still included in the CRC.
- Undefined: no FCS state and no CRC logic. Frame length on the wire = PREAMBLE_LEN + 1 + L.

Decomposition:
- Package eth_gen_pkg holds:
  - the state enum and the pattern enum;
  - constants: PREAMBLE_BYTE = 0x55, SFD_BYTE = 0xD5, CRC_POLY = 0xEDB88320, CRC_INIT = 0xFFFFFFFF, LFSR_TAPS.
- One sub-module: eth_crc32_d8, combinational next-CRC for one byte (crc_in[31:0], dat[7:0] -> crc_out[31:0]). Instantiated only when ETH_GEN_FCS_EN is defined.

Test Plan:
- FCS on; start with frame_len = 9, pattern = 0, seed = 0x31, frame_cnt = 1 -> 7x 0x55, D5, 31..39, then 26 39 F4 CB. tx_en high for exactly 21 cycles, done 12 cycles after tx_en falls, frames_sent = 1.
- frame_cnt = 3, ifg = 4, frame_len = 60 -> gaps measure exactly 12 cycles (MIN_IFG). Three frames, frames_sent = 3, a single done pulse.
- pattern = 2, seed = 0 -> payload starts 01, then follows the LFSR sequence, and restarts at 01 in the next frame. pattern = 3 -> frame 0 all 00, frame 1 all 01.
- err_en = 1, err_pos = 16, frame_len = 60 -> tx_er high exactly on payload byte 16 (cycle 8 + 16 after tx_en rises). err_pos = 60 -> tx_er never asserted.
- frame_cnt = 0, stop pulsed mid-payload of frame 2 -> frame 2 completes (including FCS and IFG), then done, busy = 0, frames_sent = 3. A start during busy is ignored.
- reset asserted mid-payload -> tx_en = 0 and busy = 0 next cycle. frame_len = 0 and 2000 -> payloads of 1 and MAX_LEN bytes.
